// File: rtl/mini_car_planner_if.sv
// ---------------------------------------------------------------------------
// mini_car_planner_if
// Groups the sensor inputs and the planner outputs of mini_car_planner.
//   enable   : run request (level, synchronous)
//   track    : 4 line sensors, 1 = line seen, bit3 = leftmost
//   obstacle : asynchronous obstacle detector, 1 = obstacle ahead
//   Action   : registered action code for the motor-action driver
//   state    : current planner state (IDLE=0 .. LOST=5)
//   busy     : high during the stop/retreat/spin sequence
//   fault    : sticky lost-line flag
// master = sensor/host side, slave = planner side.
// ---------------------------------------------------------------------------
interface mini_car_planner_if;
   logic       enable;
   logic [3:0] track;
   logic       obstacle;
   logic [3:0] Action;
   logic [2:0] state;
   logic       busy;
   logic       fault;

   modport master (
      output enable, track, obstacle,
      input  Action, state, busy, fault
   );

   modport slave (
      input  enable, track, obstacle,
      output Action, state, busy, fault
   );
endinterface

// File: rtl/mini_car_planner.sv
// ---------------------------------------------------------------------------
// mini_car_planner
// Line-following planner: decodes the line sensors into motor action codes,
// runs a timed stop/retreat/spin sequence when an obstacle is seen, searches
// using the last turn direction when the line is lost and raises a sticky
// fault if searching takes too long.
// Ports:
//   clk_in : system clock, all logic on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mini_car_planner_if.slave (enable, track, obstacle in;
//            Action, state, busy, fault out)
// Parameters:
//   TICK_DIV   : clk_in cycles per 1 ms tick
//   STOP_MS    : ms held in STOP before retreating
//   RETREAT_MS : ms spent retreating (BACK)
//   SPIN_MS    : ms spent spinning (SPIN)
//   LOST_MS    : ms of searching before a fault is declared
// ---------------------------------------------------------------------------
module mini_car_planner #(
   parameter int unsigned TICK_DIV   = 100000,
   parameter int unsigned STOP_MS    = 100,
   parameter int unsigned RETREAT_MS = 300,
   parameter int unsigned SPIN_MS    = 400,
   parameter int unsigned LOST_MS    = 1000
) (
   input logic              clk_in,
   input logic              rst_n,
   mini_car_planner_if.slave bus
);

   localparam logic [3:0] ACT_SLOW    = 4'h1;
   localparam logic [3:0] ACT_NORM    = 4'h2;
   localparam logic [3:0] ACT_FAST    = 4'h3;
   localparam logic [3:0] ACT_TURN_L  = 4'h4;
   localparam logic [3:0] ACT_TURN_R  = 4'h5;
   localparam logic [3:0] ACT_STURN_L = 4'h6;
   localparam logic [3:0] ACT_STURN_R = 4'h7;
   localparam logic [3:0] ACT_REV_L   = 4'h8;
   localparam logic [3:0] ACT_RETREAT = 4'hA;
   localparam logic [3:0] ACT_STOP    = 4'hF;

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MAX_AB = (STOP_MS > RETREAT_MS) ? STOP_MS : RETREAT_MS;
   localparam int unsigned MAX_CD = (SPIN_MS > LOST_MS) ? SPIN_MS : LOST_MS;
   localparam int unsigned MS_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MW = $clog2(MS_MAX + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TRACK = 3'd1,
      STOP  = 3'd2,
      BACK  = 3'd3,
      SPIN  = 3'd4,
      LOST  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      TURN_NONE = 2'd0,
      TURN_L    = 2'd1,
      TURN_R    = 2'd2
   } turn_t;

   state_t          st;
   turn_t           last_turn;
   logic [3:0]      action_q;
   logic            busy_q;
   logic            fault_q;
   logic            obs_meta;
   logic            obs_s;
   logic [PW-1:0]   presc;
   logic [MW-1:0]   ms_cnt;
   logic            tick;
   logic            stop_done;
   logic            back_done;
   logic            spin_done;
   logic            lost_done;
   logic [3:0]      track_code;

   // Sensor pattern to action code; 0000 never reaches this (handled as LOST).
   function automatic logic [3:0] decode(input logic [3:0] t);
      logic [3:0] code;
      case (t)
         4'b0110:          code = ACT_FAST;
         4'b0100:          code = ACT_TURN_L;
         4'b0010:          code = ACT_TURN_R;
         4'b1000, 4'b1100: code = ACT_STURN_L;
         4'b0001, 4'b0011: code = ACT_STURN_R;
         4'b1111:          code = ACT_NORM;
         default:          code = ACT_SLOW;
      endcase
      return code;
   endfunction

   assign track_code = decode(bus.track);
   assign tick       = (presc == PW'(TICK_DIV - 1));

   // A timed state exits on the tick that brings the ms counter to N.
   assign stop_done = tick && (ms_cnt == MW'(STOP_MS - 1));
   assign back_done = tick && (ms_cnt == MW'(RETREAT_MS - 1));
   assign spin_done = tick && (ms_cnt == MW'(SPIN_MS - 1));
   assign lost_done = tick && (ms_cnt == MW'(LOST_MS - 1));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         obs_meta <= 1'b0;
         obs_s    <= 1'b0;
      end else begin
         obs_meta <= bus.obstacle;
         obs_s    <= obs_meta;
      end
   end

   // Every state entry below also clears presc/ms_cnt; those later
   // non-blocking writes override the free-running update at the top.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         action_q  <= ACT_STOP;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
         last_turn <= TURN_NONE;
         presc     <= '0;
         ms_cnt    <= '0;
      end else begin
         presc  <= tick ? '0 : presc + PW'(1);
         ms_cnt <= tick ? ms_cnt + MW'(1) : ms_cnt;

         if (!bus.enable) begin
            st       <= IDLE;
            action_q <= ACT_STOP;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            presc    <= '0;
            ms_cnt   <= '0;
         end else begin
            case (st)
               IDLE: begin
                  action_q <= ACT_STOP;
                  if (!fault_q) begin
                     st     <= TRACK;
                     presc  <= '0;
                     ms_cnt <= '0;
                  end
               end

               TRACK: begin
                  if (obs_s) begin
                     st       <= STOP;
                     action_q <= ACT_STOP;
                     busy_q   <= 1'b1;
                     presc    <= '0;
                     ms_cnt   <= '0;
                  end else if (bus.track == '0) begin
                     st     <= LOST;
                     presc  <= '0;
                     ms_cnt <= '0;
                     case (last_turn)
                        TURN_L:  action_q <= ACT_STURN_L;
                        TURN_R:  action_q <= ACT_STURN_R;
                        default: action_q <= ACT_SLOW;
                     endcase
                  end else begin
                     action_q <= track_code;
                     if (track_code == ACT_TURN_L || track_code == ACT_STURN_L)
                        last_turn <= TURN_L;
                     else if (track_code == ACT_TURN_R || track_code == ACT_STURN_R)
                        last_turn <= TURN_R;
                  end
               end

               STOP: begin
                  if (stop_done) begin
                     st       <= BACK;
                     action_q <= ACT_RETREAT;
                     presc    <= '0;
                     ms_cnt   <= '0;
                  end
               end

               BACK: begin
                  if (back_done) begin
                     st       <= SPIN;
                     action_q <= ACT_REV_L;
                     presc    <= '0;
                     ms_cnt   <= '0;
                  end
               end

               SPIN: begin
                  if (spin_done) begin
                     st     <= TRACK;
                     busy_q <= 1'b0;
                     presc  <= '0;
                     ms_cnt <= '0;
                  end
               end

               LOST: begin
                  if (obs_s) begin
                     st       <= STOP;
                     action_q <= ACT_STOP;
                     busy_q   <= 1'b1;
                     presc    <= '0;
                     ms_cnt   <= '0;
                  end else if (bus.track != '0) begin
                     st     <= TRACK;
                     presc  <= '0;
                     ms_cnt <= '0;
                  end else if (lost_done) begin
                     st       <= IDLE;
                     action_q <= ACT_STOP;
                     fault_q  <= 1'b1;
                     presc    <= '0;
                     ms_cnt   <= '0;
                  end
               end

               default: begin
                  st       <= IDLE;
                  action_q <= ACT_STOP;
                  busy_q   <= 1'b0;
                  presc    <= '0;
                  ms_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.Action = action_q;
   assign bus.state  = st;
   assign bus.busy   = busy_q;
   assign bus.fault  = fault_q;

endmodule

// File: tb/tb_mini_car_planner.sv
// ---------------------------------------------------------------------------
// tb_mini_car_planner
// Directed bench for mini_car_planner with small timing parameters.
// Stimulus pushes each expected output change {state, Action, busy, fault}
// with the cycle it must appear in; a monitor pops an entry whenever the DUT
// outputs change and compares value and cycle.
// ---------------------------------------------------------------------------
module tb_mini_car_planner;

   logic clk_in;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mini_car_planner_if bus();

   mini_car_planner #(
      .TICK_DIV   (4),
      .STOP_MS    (2),
      .RETREAT_MS (3),
      .SPIN_MS    (2),
      .LOST_MS    (5)
   ) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [8:0] t;
      int         at;
      string      name;
   } exp_t;

   exp_t q[$];

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [8:0] pk(input logic [2:0] s, input logic [3:0] a,
                                     input logic b, input logic f);
      return {s, a, b, f};
   endfunction

   task automatic expect_at(input int d, input logic [8:0] t, input string name);
      exp_t e;
      e.t    = t;
      e.at   = cyc + d;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Monitor: every output change must match the next expected entry.
   initial begin
      logic [8:0] prev;
      logic [8:0] cur;
      exp_t       e;
      prev = 9'h1FF;
      forever begin
         @(negedge clk_in);
         cur = {bus.state, bus.Action, bus.busy, bus.fault};
         if (cur !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_change: got state=%0d action=%h busy=%b fault=%b at cycle %0d, want no change",
                        cur[8:6], cur[5:2], cur[1], cur[0], cyc);
            end else begin
               e = q.pop_front();
               if (cur !== e.t || cyc != e.at) begin
                  n_bad++;
                  $display("FAIL %s: got state=%0d action=%h busy=%b fault=%b at cycle %0d, want state=%0d action=%h busy=%b fault=%b at cycle %0d",
                           e.name, cur[8:6], cur[5:2], cur[1], cur[0], cyc,
                           e.t[8:6], e.t[5:2], e.t[1], e.t[0], e.at);
               end
            end
            prev = cur;
         end
      end
   end

   task automatic check_now(input string name, input logic [8:0] want);
      logic [8:0] got;
      got = {bus.state, bus.Action, bus.busy, bus.fault};
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got state=%0d action=%h busy=%b fault=%b, want state=%0d action=%h busy=%b fault=%b",
                  name, got[8:6], got[5:2], got[1], got[0],
                  want[8:6], want[5:2], want[1], want[0]);
      end
   endtask

   initial begin
      exp_t e;
      rst_n        = 1'b1;
      bus.enable   = 1'b0;
      bus.track    = 4'b0000;
      bus.obstacle = 1'b0;

      // Reset
      #2;
      expect_at(1, pk(3'd0, 4'hF, 1'b0, 1'b0), "reset");
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(1);

      // Enable with centred line
      bus.enable = 1'b1;
      bus.track  = 4'b0110;
      expect_at(1, pk(3'd1, 4'hF, 1'b0, 1'b0), "idle_to_track");
      expect_at(2, pk(3'd1, 4'h3, 1'b0, 1'b0), "fast");
      step(4);

      // Obstacle pulse: full stop/retreat/spin sequence
      bus.obstacle = 1'b1;
      expect_at(3,  pk(3'd2, 4'hF, 1'b1, 1'b0), "stop");
      expect_at(11, pk(3'd3, 4'hA, 1'b1, 1'b0), "back");
      expect_at(23, pk(3'd4, 4'h8, 1'b1, 1'b0), "spin");
      expect_at(31, pk(3'd1, 4'h8, 1'b0, 1'b0), "spin_to_track");
      expect_at(32, pk(3'd1, 4'h3, 1'b0, 1'b0), "track_resume");
      step(3);
      bus.obstacle = 1'b0;
      step(31);

      // Left turn, then line lost until timeout
      bus.track = 4'b0100;
      expect_at(1, pk(3'd1, 4'h4, 1'b0, 1'b0), "turn_left");
      step(1);
      bus.track = 4'b0000;
      expect_at(1,  pk(3'd5, 4'h6, 1'b0, 1'b0), "lost_left");
      expect_at(21, pk(3'd0, 4'hF, 1'b0, 1'b1), "lost_timeout");
      step(24);
      bus.enable = 1'b0;
      expect_at(1, pk(3'd0, 4'hF, 1'b0, 1'b0), "fault_clear");
      step(1);
      bus.enable = 1'b1;
      bus.track  = 4'b0110;
      expect_at(1, pk(3'd1, 4'hF, 1'b0, 1'b0), "retrack");
      expect_at(2, pk(3'd1, 4'h3, 1'b0, 1'b0), "retrack_fast");
      step(3);

      // Obstacle and empty track together: STOP wins; then abort mid-BACK
      bus.obstacle = 1'b1;
      step(2);
      bus.track = 4'b0000;
      expect_at(1, pk(3'd2, 4'hF, 1'b1, 1'b0), "stop_beats_lost");
      expect_at(9, pk(3'd3, 4'hA, 1'b1, 1'b0), "back2");
      step(1);
      bus.obstacle = 1'b0;
      step(12);
      bus.enable = 1'b0;
      expect_at(1, pk(3'd0, 4'hF, 1'b0, 1'b0), "abort_back");
      step(2);

      // Right turn memory, line recovery, remaining decode patterns
      bus.enable = 1'b1;
      bus.track  = 4'b0010;
      expect_at(1, pk(3'd1, 4'hF, 1'b0, 1'b0), "track3");
      expect_at(2, pk(3'd1, 4'h5, 1'b0, 1'b0), "turn_right");
      step(2);
      bus.track = 4'b0000;
      expect_at(1, pk(3'd5, 4'h7, 1'b0, 1'b0), "lost_right");
      step(3);
      bus.track = 4'b1000;
      expect_at(1, pk(3'd1, 4'h7, 1'b0, 1'b0), "found_line");
      expect_at(2, pk(3'd1, 4'h6, 1'b0, 1'b0), "sharp_left");
      step(2);
      bus.track = 4'b1010;
      expect_at(1, pk(3'd1, 4'h1, 1'b0, 1'b0), "other_slow");
      step(1);
      bus.track = 4'b1111;
      expect_at(1, pk(3'd1, 4'h2, 1'b0, 1'b0), "all_norm");
      step(1);
      bus.track = 4'b0011;
      expect_at(1, pk(3'd1, 4'h7, 1'b0, 1'b0), "sharp_right");
      step(1);
      bus.track = 4'b0110;
      expect_at(1, pk(3'd1, 4'h3, 1'b0, 1'b0), "fast2");
      step(2);

      // Asynchronous reset in the middle of SPIN
      bus.obstacle = 1'b1;
      expect_at(3,  pk(3'd2, 4'hF, 1'b1, 1'b0), "stop3");
      expect_at(11, pk(3'd3, 4'hA, 1'b1, 1'b0), "back3");
      expect_at(23, pk(3'd4, 4'h8, 1'b1, 1'b0), "spin3");
      step(3);
      bus.obstacle = 1'b0;
      step(22);
      expect_at(0, pk(3'd0, 4'hF, 1'b0, 1'b0), "async_reset");
      #2;
      rst_n = 1'b0;
      #1;
      check_now("async_reset_now", pk(3'd0, 4'hF, 1'b0, 1'b0));
      bus.enable = 1'b0;
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      step(3);

      // Drain with a bounded wait
      for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
      while (q.size() != 0) begin
         e = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no output change, want state=%0d action=%h busy=%b fault=%b at cycle %0d",
                  e.name, e.t[8:6], e.t[5:2], e.t[1], e.t[0], e.at);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mini_car_planner.md
MINI_CAR_PLANNER -- requirements
Module: mini_car_planner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk_in cycles per 1 ms tick (100 MHz).
REQ-002 SHALL have parameter STOP_MS, default 100, ms held in Stop before retreating.
REQ-003 SHALL have parameter RETREAT_MS, default 300, ms spent in Retreat.
REQ-004 SHALL have parameter SPIN_MS, default 400, ms spent in Reverse_Left.
REQ-005 SHALL have parameter LOST_MS, default 1000, ms of searching before a fault is declared.
REQ-006 SHALL have port clk_in, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-008 SHALL have port enable, input, 1, run request, level-sensitive, synchronous to clk_in.
REQ-009 SHALL have port track, input, 4, line sensors; 1 = line seen; bit3 = leftmost; synchronous.
REQ-010 SHALL have port obstacle, input, 1, asynchronous obstacle detector; 1 = obstacle ahead.
REQ-011 SHALL have port Action, output, 4, registered action code for the motor-action driver.
REQ-012 SHALL have port state, output, 3, current state: IDLE=0, TRACK=1, STOP=2, BACK=3, SPIN=4, LOST=5.
REQ-013 SHALL have port busy, output, 1, high while in STOP, BACK or SPIN.
REQ-014 SHALL have port fault, output, 1, sticky lost-line flag.

Function
REQ-015 SHALL use these action codes: Slow 4'h1, Norm 4'h2, Fast 4'h3, Turn_Left 4'h4, Turn_Right 4'h5, sTurn_Left 4'h6, sTurn_Right 4'h7, Reverse_Left 4'h8, Retreat 4'hA, Stop 4'hF.
REQ-016 SHALL pass obstacle through a 2-flop synchronizer; obs_s is the synchronizer output.
REQ-017 SHALL apply transition priority: enable==0 over obs_s over track.
REQ-018 SHALL go to IDLE on the next edge from any state when enable==0; IDLE drives Action=F.
REQ-019 SHALL, in IDLE with enable==1, go to TRACK if fault==0; fault==1 keeps IDLE.
REQ-020 SHALL, in TRACK, register Action from track with 1-cycle latency:
- 0110 -> 3
- 0100 -> 4
- 0010 -> 5
- 1000 or 1100 -> 6
- 0001 or 0011 -> 7
- 1111 -> 2
- 0000 -> enter LOST
- any other pattern -> 1
REQ-021 SHALL keep a last-turn memory updated in TRACK: L on codes 4/6, R on 5/7, unchanged otherwise; reset value none.
REQ-022 SHALL go from TRACK to STOP when obs_s==1 (takes priority over track).
REQ-023 SHALL sequence STOP (Action F, STOP_MS) -> BACK (Action A, RETREAT_MS) -> SPIN (Action 8, SPIN_MS) -> TRACK.
REQ-024 SHALL ignore obs_s during STOP, BACK and SPIN; only enable==0 aborts the sequence.
REQ-025 SHALL drive Action in LOST from last-turn memory: L -> 6, R -> 7, none -> 1.
REQ-026 SHALL leave LOST for TRACK on the first cycle track!=0; obs_s==1 in LOST goes to STOP.
REQ-027 SHALL, after LOST_MS in LOST, go to IDLE and set fault=1.
REQ-028 SHALL clear fault only while enable==0 (or on reset).
REQ-029 SHALL implement timing with a prescaler and an ms counter:
- both cleared on every state entry
- prescaler pulses a tick at count TICK_DIV-1, then wraps to 0
- the ms counter increments on each tick
REQ-030 SHALL make a timed state last exactly N*TICK_DIV cycles; the exit happens on the tick that brings the ms counter to N.
REQ-031 SHALL change Action on the same edge as the state transition it belongs to.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear:
- state=IDLE, Action=F
- busy=0, fault=0
- prescaler and ms counter to 0
- synchronizer flops to 0
- last-turn memory to none

Verification (TICK_DIV=4, STOP_MS=2, RETREAT_MS=3, SPIN_MS=2, LOST_MS=5)
REQ-033 SHALL cover: reset release, enable=1, track=0110 -> state 1 next edge, Action=3 one cycle later.
REQ-034 SHALL cover: obstacle pulse of 3 cycles in TRACK -> STOP 2-3 cycles after the edge; Action F for 8 cycles, A for 12, 8 for 8; busy high for 28 cycles; then TRACK.
REQ-035 SHALL cover: track=0100 then 0000 -> Action 4, then LOST with Action 6; no line for 20 cycles -> IDLE, fault=1, Action F; enable 0 then 1 -> fault cleared, TRACK.
REQ-036 SHALL cover: enable=0 mid-BACK -> IDLE and Action F next edge, busy=0.
REQ-037 SHALL cover: rst_n low mid-SPIN, asynchronously (no clock edge) -> Action F, state 0, fault 0 immediately.
REQ-038 SHALL cover: obstacle and track=0000 in the same cycle in TRACK -> STOP wins.
